// File: rtl/param_register_file_if.sv
// Register-file access bundle: write/read addresses, write data, PC, clear request and the four read results.
// The master modport is the decode/writeback side; the slave modport is the register file itself.
interface param_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 12
);
    logic              clear_req;
    logic              busy;
    logic              write_enable;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_address1;
    logic [ADDR_W-1:0] read_address2;
    logic [PC_W-1:0]   program_counter;
    logic [DATA_W-1:0] data_dest;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] data_status;

    modport master (
        output clear_req, write_enable, write_address, write_data,
               read_address1, read_address2, program_counter,
        input  busy, data_dest, data_a, data_b, data_status
    );

    modport slave (
        input  clear_req, write_enable, write_address, write_data,
               read_address1, read_address2, program_counter,
        output busy, data_dest, data_a, data_b, data_status
    );
endinterface

// File: rtl/param_register_file.sv
// Multi-port register file: three combinational reads, one status read, one write, PC capture, clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle commits onto the read ports.
module param_register_file #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int PC_W       = 12,
    parameter int PC_REG     = 28,
    parameter int PC_LIMIT   = 256,
    parameter int STATUS_REG = 30
) (
    input  logic                   clock,
    input  logic                   reset,
    param_register_file_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PcRegAddr     = ADDR_W'(PC_REG);
    localparam logic [ADDR_W-1:0] StatusRegAddr = ADDR_W'(STATUS_REG);
    localparam logic [ADDR_W-1:0] LastIdx       = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} stateType;

    stateType          state;
    stateType          stateNext;
    logic [ADDR_W-1:0] clrIdx;
    logic [ADDR_W-1:0] clrIdxNext;

    logic [DATA_W-1:0] regs [DEPTH];

    logic              clrEn;
    logic              wrEn;
    logic              capEn;
    logic              capHit;
    logic [DATA_W-1:0] pcExt;

    assign capHit = 32'(bus.program_counter) < 32'(PC_LIMIT);
    assign pcExt  = DATA_W'(bus.program_counter);

    // State register: reset restarts the sweep from entry 0, even mid-sweep.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= CLEAR;
            clrIdx <= '0;
        end else begin
            state  <= stateNext;
            clrIdx <= clrIdxNext;
        end
    end

    always_comb begin
        stateNext  = state;
        clrIdxNext = clrIdx;
        case (state)
            CLEAR: begin
                clrIdxNext = clrIdx + 1'b1;
                if (clrIdx == LastIdx) stateNext = IDLE;
            end
            IDLE: begin
                if (bus.clear_req) begin
                    stateNext  = CLEAR;
                    clrIdxNext = '0;
                end
            end
            default: stateNext = CLEAR;
        endcase
    end

    // The array is left untouched in a reset cycle; writes and capture only commit in IDLE.
    always_comb begin
        bus.busy = (state == CLEAR);
        clrEn    = 1'b0;
        wrEn     = 1'b0;
        capEn    = 1'b0;
        if (!reset) begin
            if (state == CLEAR) begin
                clrEn = 1'b1;
            end else begin
                wrEn  = bus.write_enable;
                capEn = capHit;
            end
        end
    end

    // Capture is assigned last so the PC wins a collision at PC_REG.
    always_ff @(posedge clock) begin
        if (clrEn) begin
            regs[clrIdx] <= '0;
        end else begin
            if (wrEn)  regs[bus.write_address] <= bus.write_data;
            if (capEn) regs[PcRegAddr]         <= pcExt;
        end
    end

    function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        value = regs[addr];
`ifdef REGFILE_BYPASS_EN
        if (wrEn && addr == bus.write_address) value = bus.write_data;
        if (capEn && addr == PcRegAddr)        value = pcExt;
`endif
        if (state == CLEAR) value = '0;
        return value;
    endfunction

    always_comb begin
        bus.data_dest   = readPort(bus.write_address);
        bus.data_a      = readPort(bus.read_address1);
        bus.data_b      = readPort(bus.read_address2);
        bus.data_status = readPort(StatusRegAddr);
    end
endmodule
